// File: rtl/rd_req_arbiter_pkg.sv
// Shared AXI read-channel constants and requester ID assignments for the
// graph-engine fetchers and their read arbiter.
package rd_req_arbiter_pkg;

    localparam logic [2:0] SIZE_64B   = 3'b110;
    localparam logic [7:0] LEN_SINGLE = 8'd0;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ID_VERT   = 2'd0,
        ID_INEDGE = 2'd1,
        ID_PR     = 2'd2
    } req_id_e;

    // Requests are issued as whole 64-byte lines.
    function automatic logic [63:0] line_align(input logic [63:0] addr);
        return addr & ~64'h3F;
    endfunction

endpackage

// File: rtl/rd_req_arbiter_picker.sv
// Round-robin picker with a strict-priority class: flagged requesters win over
// unflagged ones, and the search within a class starts at ptr_i.
module rr_prio_picker #(
    parameter int           N    = 3,
    parameter logic [N-1:0] MASK = '0,
    parameter int           PW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] grant_idx_o,
    output logic          grant_any_o
);

    logic [N-1:0] hi_req;
    logic [N-1:0] cand;
    int           idx;

    assign hi_req = req_i & MASK;
    assign cand   = (|hi_req) ? hi_req : (req_i & ~MASK);

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        grant_any_o = 1'b0;
        idx         = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!grant_any_o && cand[idx]) begin
                grant_any_o  = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/rd_req_arbiter.sv
// Shares one AXI AR/R channel pair among N_REQ read streams: arbitrates onto AR
// with arid = requester index, enforces per-requester credits, routes R by rid.
module rd_req_arbiter
    import rd_req_arbiter_pkg::*;
#(
    parameter int               N_REQ     = 3,
    parameter int               MAX_OUT   = 4,
    parameter logic [N_REQ-1:0] PRIO_MASK = 3'b100,
    parameter int               ID_W      = 16,
    parameter int               DATA_W    = 512
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*64-1:0] req_addr,
    output logic [N_REQ-1:0]    req_ready,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    input  logic [N_REQ-1:0]    rsp_ready,
    output logic [ID_W-1:0]     arid_m,
    output logic [63:0]         araddr_m,
    output logic [7:0]          arlen_m,
    output logic [2:0]          arsize_m,
    output logic                arvalid_m,
    input  logic                arready_m,
    input  logic [ID_W-1:0]     rid_m,
    input  logic [DATA_W-1:0]   rdata_m,
    input  logic [1:0]          rresp_m,
    input  logic                rlast_m,
    input  logic                rvalid_m,
    output logic                rready_m,
    output logic                idle,
    output logic                err_valid,
    output logic [ID_W-1:0]     err_id
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [N_REQ-1:0] eligible, grant, rid_hit, cnt_inc, cnt_dec, cnt_zero, dec_zero;
    logic [PTR_W-1:0] grant_idx, rr_ptr_q, rr_ptr_d;
    logic             grant_any, can_accept, accept;
    logic             arvalid_q, arvalid_d;
    logic [63:0]      araddr_q, araddr_d;
    logic [ID_W-1:0]  arid_q, arid_d;
    logic             rid_known, r_hs, r_done, err_now;
    logic             err_valid_q;
    logic [ID_W-1:0]  err_id_q;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        logic [CNT_W-1:0] cnt_q, cnt_d;

        assign eligible[gi] = req_valid[gi] && (cnt_q < CNT_W'(MAX_OUT));
        assign rid_hit[gi]  = (rid_m == ID_W'(gi));
        assign cnt_inc[gi]  = accept && grant[gi];
        assign cnt_dec[gi]  = r_done && rid_hit[gi];
        assign cnt_zero[gi] = (cnt_q == '0);
        assign dec_zero[gi] = cnt_dec[gi] && cnt_zero[gi];

        // Credit is charged at grant so a stalled AR never over-commits.
        always_comb begin
            cnt_d = cnt_q;
            if (cnt_inc[gi] && !cnt_dec[gi])
                cnt_d = cnt_q + CNT_W'(1);
            else if (cnt_dec[gi] && !cnt_inc[gi] && !cnt_zero[gi])
                cnt_d = cnt_q - CNT_W'(1);
        end

        always_ff @(posedge clk) begin
            if (rst) cnt_q <= '0;
            else     cnt_q <= cnt_d;
        end
    end

    rr_prio_picker #(
        .N    (N_REQ),
        .MASK (PRIO_MASK),
        .PW   (PTR_W)
    ) u_picker (
        .req_i       (eligible),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .grant_any_o (grant_any)
    );

    assign can_accept = !arvalid_q || arready_m;
    assign accept     = can_accept && grant_any;
    assign req_ready  = can_accept ? grant : '0;

    always_comb begin
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        arid_d    = arid_q;
        rr_ptr_d  = rr_ptr_q;
        if (accept) begin
            arvalid_d = 1'b1;
            araddr_d  = line_align(req_addr[64*grant_idx +: 64]);
            arid_d    = ID_W'(grant_idx);
            rr_ptr_d  = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
        end else if (arready_m) begin
            arvalid_d = 1'b0;
        end
    end

    // Unknown rids are always accepted so a stray beat cannot wedge the bus.
    assign rid_known = |rid_hit;
    assign rready_m  = rid_known ? |(rid_hit & rsp_ready) : 1'b1;
    assign rsp_valid = rvalid_m ? rid_hit : '0;
    assign rsp_data  = rdata_m;
    assign r_hs      = rvalid_m && rready_m;
    assign r_done    = r_hs && rlast_m;
    assign err_now   = (r_hs && (rresp_m != RESP_OKAY)) || (rvalid_m && !rid_known) || (|dec_zero);

    always_ff @(posedge clk) begin
        if (rst) begin
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            arid_q      <= '0;
            rr_ptr_q    <= '0;
            err_valid_q <= 1'b0;
            err_id_q    <= '0;
        end else begin
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            arid_q    <= arid_d;
            rr_ptr_q  <= rr_ptr_d;
            if (err_now && !err_valid_q) begin
                err_valid_q <= 1'b1;
                err_id_q    <= rid_m;
            end
        end
    end

    assign arvalid_m = arvalid_q;
    assign araddr_m  = araddr_q;
    assign arid_m    = arid_q;
    assign arlen_m   = LEN_SINGLE;
    assign arsize_m  = SIZE_64B;
    assign idle      = !arvalid_q && (&cnt_zero);
    assign err_valid = err_valid_q;
    assign err_id    = err_id_q;

endmodule
